// File: rtl/io_ctrl.sv
// ============================================================================
// Module   : io_ctrl
// Brief    : Memory-mapped I/O controller that sits between the CPU data port
//            and data memory. It provides a one-entry input buffer with a
//            valid/ack handshake, a registered output port with a valid/ready
//            handshake, and a read-only status register. CPU accesses to the
//            data port that cannot complete yet freeze the CPU through stall.
//            Optional feature macro: IO_TIMEOUT_EN enables a WAIT_IN timeout
//            that returns all-ones and raises a sticky status flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_ctrl #(
  parameter logic [7:0] IO_ADDR   = 8'hFC,
  parameter logic [7:0] STAT_ADDR = 8'hFD,
  parameter int         TMO_CYC   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  addr,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        mem_we,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ack,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_IN  = 2'd1,
    WAIT_OUT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        in_full_q, in_full_d;
  logic [31:0] in_buf_q, in_buf_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        tmo_flag;

  logic        w_is_io;
  logic        w_is_stat;
  logic        w_stall;
  logic        w_ack;
  logic [31:0] w_status;

`ifdef IO_TIMEOUT_EN
  localparam logic [7:0] TMO_LIM = 8'(TMO_CYC);

  logic       tmo_q, tmo_d;
  logic [7:0] cnt_q, cnt_d;

  assign tmo_flag = tmo_q;
`else
  assign tmo_flag = 1'b0;
`endif

  assign w_is_io   = (addr == IO_ADDR);
  assign w_is_stat = (addr == STAT_ADDR);
  assign w_status  = {29'b0, tmo_flag, out_valid_q, in_full_q};

  // Outputs are suppressed while reset is asserted so an aborted access never
  // leaves the CPU frozen and no word is acknowledged that cannot be stored.
  assign stall     = rst & w_stall;
  assign in_ack    = rst & w_ack;
  assign mem_we    = we & ~w_is_io & ~w_is_stat;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  // State, buffers and handshake flags; everything clears asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      in_full_q   <= 1'b0;
      in_buf_q    <= 32'h0;
      out_data_q  <= 32'h0;
      out_valid_q <= 1'b0;
`ifdef IO_TIMEOUT_EN
      tmo_q       <= 1'b0;
      cnt_q       <= 8'h0;
`endif
    end else begin
      state_q     <= state_d;
      in_full_q   <= in_full_d;
      in_buf_q    <= in_buf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef IO_TIMEOUT_EN
      tmo_q       <= tmo_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Next-state, read-data mux, stall and handshake decode.
  always_comb begin
    state_d     = state_q;
    in_full_d   = in_full_q;
    in_buf_d    = in_buf_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    w_stall     = 1'b0;
    w_ack       = 1'b0;
`ifdef IO_TIMEOUT_EN
    tmo_d       = tmo_q;
    cnt_d       = 8'h0;
`endif

    // Address decode for the returned data; FSM branches may override it.
    if (w_is_stat) begin
      rdata = w_status;
    end else if (w_is_io) begin
      rdata = in_buf_q;
    end else begin
      rdata = mem_rdata;
    end

    // Input side runs independently of the CPU: capture only into an empty
    // buffer, so a word being consumed this cycle cannot be overwritten.
    if (in_valid && !in_full_q) begin
      in_buf_d  = in_data;
      in_full_d = 1'b1;
      w_ack     = 1'b1;
    end

    // Output handshake retires the current word; a load below re-arms it.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (re && w_is_io) begin
          if (in_full_q) begin
            in_full_d = 1'b0;
          end else begin
            w_stall = 1'b1;
            state_d = WAIT_IN;
          end
        end else if (we && w_is_io) begin
          if (!out_valid_q) begin
            out_data_d  = wdata;
            out_valid_d = 1'b1;
          end else begin
            w_stall = 1'b1;
            state_d = WAIT_OUT;
          end
        end
`ifdef IO_TIMEOUT_EN
        else if (re && w_is_stat) begin
          // Sticky flag is reported once, then cleared by the read.
          tmo_d = 1'b0;
        end
`endif
      end

      WAIT_IN: begin
        if (in_full_q) begin
          rdata     = in_buf_q;
          in_full_d = 1'b0;
          state_d   = IDLE;
        end
`ifdef IO_TIMEOUT_EN
        else if (cnt_q == TMO_LIM) begin
          rdata   = 32'hFFFF_FFFF;
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          w_stall = 1'b1;
          cnt_d   = cnt_q + 8'h1;
        end
`else
        else begin
          w_stall = 1'b1;
        end
`endif
      end

      WAIT_OUT: begin
        // The pending word may have drained on the edge that entered this
        // state, so an empty port also accepts the held store immediately.
        if (!out_valid_q || out_ready) begin
          out_data_d  = wdata;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_io_ctrl.sv
// ============================================================================
// Module   : tb_io_ctrl
// Brief    : Directed self-checking bench for io_ctrl. Define IO_TIMEOUT_EN
//            for both bench and design to exercise the timeout path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_ctrl;

  localparam logic [7:0] C_IO   = 8'hFC;
  localparam logic [7:0] C_STAT = 8'hFD;

  logic        clk;
  logic        rst;
  logic [7:0]  addr;
  logic        we;
  logic        re;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic [31:0] rdata;
  logic        stall;
  logic        mem_we;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ack;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int checks;
  int failures;
  int nstall;

  io_ctrl #(
    .IO_ADDR  (C_IO),
    .STAT_ADDR(C_STAT),
    .TMO_CYC  (255)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .we       (we),
    .re       (re),
    .wdata    (wdata),
    .mem_rdata(mem_rdata),
    .rdata    (rdata),
    .stall    (stall),
    .mem_we   (mem_we),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ack   (in_ack),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs settle 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    addr      = 8'h00;
    we        = 1'b0;
    re        = 1'b0;
    wdata     = 32'h0;
    mem_rdata = 32'h0;
    in_data   = 32'h0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // ---------------- reset state ----------------
    step();
    step();
    re   = 1'b1;
    addr = C_IO;
    #2;
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    re   = 1'b0;
    addr = 8'h00;
    step();
    rst = 1'b1;
    #2;

    // ---------------- buffered input, then load ----------------
    in_valid = 1'b1;
    in_data  = 32'hA5A5_0001;
    #1;
    chk("in_ack_first", {31'b0, in_ack}, 32'h1);
    step();
    chk("in_ack_full", {31'b0, in_ack}, 32'h0);
    in_valid = 1'b0;
    re       = 1'b1;
    addr     = C_STAT;
    #2;
    chk("stat_full", rdata, 32'h1);
    step();
    addr = C_IO;
    #2;
    chk("ld_buf_rdata", rdata, 32'hA5A5_0001);
    chk("ld_buf_stall", {31'b0, stall}, 32'h0);
    step();
    addr = C_STAT;
    #2;
    chk("stat_empty", rdata, 32'h0);
    step();

    // ---------------- load waits for late input ----------------
    addr   = C_IO;
    re     = 1'b1;
    nstall = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i == 5);
      in_data  = 32'h0000_1234;
      #2;
      if (!stall) break;
      nstall++;
      step();
    end
    chk("ld_wait_stalls", nstall, 32'd6);
    chk("ld_wait_rdata", rdata, 32'h0000_1234);
    step();
    in_valid = 1'b0;
    addr     = C_STAT;
    #2;
    chk("ld_wait_stat", rdata, 32'h0);
    step();
    re = 1'b0;

    // ---------------- store back-pressure ----------------
    out_ready = 1'b0;
    we        = 1'b1;
    addr      = C_IO;
    wdata     = 32'h55;
    #2;
    chk("st1_stall", {31'b0, stall}, 32'h0);
    chk("st1_mem_we", {31'b0, mem_we}, 32'h0);
    step();
    chk("st1_out_data", out_data, 32'h55);
    chk("st1_out_valid", {31'b0, out_valid}, 32'h1);
    wdata = 32'h66;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("st2_stall_held", {31'b0, stall}, 32'h1);
      chk("st2_data_held", out_data, 32'h55);
      step();
    end
    out_ready = 1'b1;
    #2;
    chk("st2_release", {31'b0, stall}, 32'h0);
    step();
    we        = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("st2_out_data", out_data, 32'h66);
    chk("st2_out_valid", {31'b0, out_valid}, 32'h1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #2;
    chk("drain_valid", {31'b0, out_valid}, 32'h0);
    chk("drain_data", out_data, 32'h66);

    // ---------------- plain memory and status-store ----------------
    we        = 1'b1;
    addr      = 8'h10;
    wdata     = 32'hDEAD_BEEF;
    mem_rdata = 32'hCAFE_F00D;
    #2;
    chk("mem_we_on", {31'b0, mem_we}, 32'h1);
    chk("mem_rdata", rdata, 32'hCAFE_F00D);
    step();
    chk("mem_st_out", out_data, 32'h66);
    addr = C_STAT;
    #2;
    chk("stat_st_mem_we", {31'b0, mem_we}, 32'h0);
    step();
    we = 1'b0;
    re = 1'b1;
    #2;
    chk("stat_st_nochg", rdata, 32'h0);
    chk("stat_st_out", out_data, 32'h66);
    step();
    re = 1'b0;

`ifdef IO_TIMEOUT_EN
    // ---------------- timeout ----------------
    re     = 1'b1;
    addr   = C_IO;
    nstall = 0;
    for (int i = 0; i < 400; i++) begin
      #2;
      if (!stall) break;
      nstall++;
      step();
    end
    chk("tmo_stalls", nstall, 32'd256);
    chk("tmo_rdata", rdata, 32'hFFFF_FFFF);
    step();
    addr = C_STAT;
    #2;
    chk("tmo_stat_set", rdata, 32'h4);
    step();
    #2;
    chk("tmo_stat_clr", rdata, 32'h0);
    step();
    re = 1'b0;
`endif

    // ---------------- reset in the middle of WAIT_IN ----------------
    we    = 1'b1;
    addr  = C_IO;
    wdata = 32'h77;
    step();
    we = 1'b0;
    re = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("wait_in_stall", {31'b0, stall}, 32'h1);
      step();
    end
    rst = 1'b0;
    #1;
    chk("abort_stall", {31'b0, stall}, 32'h0);
    chk("abort_out_valid", {31'b0, out_valid}, 32'h0);
    chk("abort_out_data", out_data, 32'h0);
    step();
    re  = 1'b0;
    rst = 1'b1;
    // First edge after reset release must already capture.
    in_valid = 1'b1;
    in_data  = 32'h0BAD_F00D;
    #1;
    chk("post_rst_ack", {31'b0, in_ack}, 32'h1);
    step();
    in_valid = 1'b0;
    re       = 1'b1;
    addr     = C_STAT;
    #2;
    chk("post_rst_stat", rdata, 32'h1);
    step();
    addr = C_IO;
    #2;
    chk("post_rst_load", rdata, 32'h0BAD_F00D);
    chk("post_rst_nostall", {31'b0, stall}, 32'h0);
    step();
    re = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/io_ctrl.md
IO_CTRL -- requirements
Module: io_ctrl

Interface
REQ-001 SHALL have parameter IO_ADDR, default 8'hFC, address of the data port.
REQ-002 SHALL have parameter STAT_ADDR, default 8'hFD, address of the read-only status register.
REQ-003 SHALL have parameter TMO_CYC, default 255, timeout limit in cycles (used only with IO_TIMEOUT_EN).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 addr  input  8  CPU data address.
REQ-007 we, re  input  1 each  CPU store / load request; never both high.
REQ-008 wdata  input  32  CPU store data.
REQ-009 mem_rdata  input  32  data memory read data.
REQ-010 rdata  output  32  read data returned to CPU register file.
REQ-011 stall  output  1  CPU freeze request; combinational.
REQ-012 mem_we  output  1  data memory write enable; we gated off for IO_ADDR/STAT_ADDR.
REQ-013 in_data  input  32  external input word.
REQ-014 in_valid, in_ack  input/output  1 each  input handshake.
REQ-015 out_data  output  32  registered output port.
REQ-016 out_valid, out_ready  output/input  1 each  output handshake.

Function
REQ-017 Input buffer: one 32-bit entry plus flag in_full; when in_valid=1 and in_full=0, capture in_data, set in_full, drive in_ack=1 for exactly that cycle.
REQ-018 in_ack SHALL be 0 whenever in_full=1 or in_valid=0.
REQ-019 FSM states IDLE, WAIT_IN, WAIT_OUT; reset state IDLE.
REQ-020 IDLE, re=1, addr=IO_ADDR, in_full=1: rdata=buffer, stall=0, clear in_full at edge; same-cycle recapture forbidden.
REQ-021 IDLE, re=1, addr=IO_ADDR, in_full=0: stall=1, go WAIT_IN.
REQ-022 WAIT_IN: stall=1 until in_full=1; then rdata=buffer, stall=0, clear in_full, go IDLE; minimum load latency from in_valid rise is 2 cycles.
REQ-023 IDLE, we=1, addr=IO_ADDR, out_valid=0: load out_data=wdata, set out_valid, stall=0.
REQ-024 IDLE, we=1, addr=IO_ADDR, out_valid=1: stall=1, go WAIT_OUT; on out_ready load wdata, keep out_valid=1, stall=0, go IDLE.
REQ-025 out_valid SHALL clear on the edge where out_valid=1 and out_ready=1 unless a new write loads that edge.
REQ-026 Read addr=STAT_ADDR: rdata={29'b0, tmo_flag, out_valid, in_full}, no stall, no side effects.
REQ-027 Any other address: rdata=mem_rdata, mem_we=we, stall=0.
REQ-028 mem_we SHALL be 0 for IO_ADDR and STAT_ADDR; stores to STAT_ADDR ignored.
REQ-029 out_data SHALL hold its value when no write occurs; never changes while out_valid=1 and out_ready=0.

Reset
REQ-030 On rst=0, immediately: state=IDLE, in_full=0, buffer=0, out_data=32'h0, out_valid=0, tmo_flag=0, counter=0.
REQ-031 Reset during WAIT_IN/WAIT_OUT SHALL abort the access; stall=0 while rst=0.
REQ-032 First capture permitted on the first rising edge after rst deasserts.

Configuration
REQ-033 Macro IO_TIMEOUT_EN defined: 8-bit counter increments each WAIT_IN cycle; at TMO_CYC, rdata=32'hFFFFFFFF, stall=0, tmo_flag=1, go IDLE; counter clears on leaving WAIT_IN.
REQ-034 tmo_flag SHALL clear on a read of STAT_ADDR (after returning 1).
REQ-035 Macro absent: no counter, WAIT_IN waits indefinitely, status bit 2 reads 0.

Verification
REQ-036 Reset mid-WAIT_IN: re on IO_ADDR, in_valid=0 3 cycles, pulse rst -> stall=0, state IDLE, out_valid=0, out_data=0.
REQ-037 in_valid=1 in_data=32'hA5A5_0001 with no load -> in_ack one cycle, status reads 32'h1; load IO_ADDR -> rdata=32'hA5A5_0001, no stall, status then 32'h0.
REQ-038 Load IO_ADDR with buffer empty, in_valid after 5 cycles with 32'h1234 -> stall high 6 cycles, rdata=32'h1234.
REQ-039 Store 32'h55 to IO_ADDR, out_ready=0, second store 32'h66 -> stall until out_ready=1, then out_data=32'h66, out_valid=1.
REQ-040 Store to addr 8'h10 -> mem_we=1, out_data unchanged; store to 8'hFD -> mem_we=0, no state change.
REQ-041 With IO_TIMEOUT_EN, load IO_ADDR, no input 255 cycles -> rdata=32'hFFFFFFFF, stall drops, status=32'h4 then 32'h0.
